// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU operation encodings and
// the multi-cycle controller state type.
package exe_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: consumes one multiplier bit per cycle and
// keeps the low N bits of the product. 'last' marks the cycle whose edge
// performs the final iteration; 'done' is high for one cycle once the
// product is final.
module mul_iter
  import exe_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         clear,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] NITER = CW'(N);

  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  assign last    = run_q && (cnt_q == NITER - CW'(1));
  assign done    = run_q && (cnt_q == NITER);
  assign product = acc_q;

  // Next-state: clear beats start, start beats iterating; drop run after done.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b0;
    end else if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q && (cnt_q != NITER)) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end else if (done) begin
      run_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/execute_mc.sv
// Execute stage with single-cycle ALU ops and an optional multi-cycle
// multiply. Owns the IDLE/MUL/DONE controller and the result registers.
module execute_mc
  import exe_pkg::*;
#(
  parameter int N      = 64,
  parameter int MUL_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic         flush,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         busy,
  output logic         valid_out,
  output logic         zero_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M
);

  state_e       state_q, state_d;
  logic         valid_q, valid_d;
  logic         zero_q, zero_d;
  logic [N-1:0] pcb_q, pcb_d;
  logic [N-1:0] alu_q, alu_d;
  logic [N-1:0] wd_q, wd_d;

  logic [N-1:0] b_op;
  logic [N-1:0] alu_res;
  logic         is_mul;
  logic         accept;
  logic         mul_last;
  logic         mul_done;
  logic [N-1:0] mul_prod;

  function automatic logic [N-1:0] alu_comb(input logic [3:0] ctrl,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [N-1:0] r;
    case (ctrl)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_PASS: r = b;
      ALU_NOR:  r = ~(a | b);
      default:  r = '0;  // MUL is produced by mul_iter; unknown codes give 0
    endcase
    return r;
  endfunction

  assign busy    = (state_q != IDLE);
  assign b_op    = AluSrc ? signImm_E : readData2_E;
  assign alu_res = alu_comb(AluControl, readData1_E, b_op);
  assign is_mul  = (MUL_EN != 0) && (AluControl == ALU_MUL);
  assign accept  = valid_in && !busy && !flush;

  mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .clear   (flush),
    .a       (readData1_E),
    .b       (b_op),
    .last    (mul_last),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Controller and result next-state; flush overrides accept and completion.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    zero_d  = zero_q;
    pcb_d   = pcb_q;
    alu_d   = alu_q;
    wd_d    = wd_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            pcb_d = PC_E + (signImm_E << 2);
            wd_d  = readData2_E;
            if (is_mul) begin
              state_d = MUL;
            end else begin
              alu_d   = alu_res;
              zero_d  = (alu_res == '0);
              valid_d = 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_last) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          alu_d   = mul_prod;
          zero_d  = (mul_prod == '0);
          valid_d = mul_done;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      pcb_q   <= '0;
      alu_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      pcb_q   <= pcb_d;
      alu_q   <= alu_d;
      wd_q    <= wd_d;
    end
  end

  assign valid_out   = valid_q;
  assign zero_M      = zero_q;
  assign PCBranch_M  = pcb_q;
  assign aluResult_M = alu_q;
  assign writeData_M = wd_q;

endmodule

// File: tb/tb_execute_mc.sv
// Self-checking bench for execute_mc with a behavioural reference model.
module tb_execute_mc;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         flush;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
  logic         busy, valid_out, zero_M;
  logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;

  int n_checks = 0;
  int n_fail   = 0;

  execute_mc #(.N(N), .MUL_EN(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .flush       (flush),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .busy        (busy),
    .valid_out   (valid_out),
    .zero_M      (zero_M),
    .PCBranch_M  (PCBranch_M),
    .aluResult_M (aluResult_M),
    .writeData_M (writeData_M)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operation rules.
  function automatic logic [N-1:0] model_alu(input logic [3:0] c,
                                             input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      4'b1000: return a * b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic set_op(input logic [3:0] c, input logic src,
                        input logic [N-1:0] pc, input logic [N-1:0] imm,
                        input logic [N-1:0] a, input logic [N-1:0] rd2);
    valid_in    = 1'b1;
    AluControl  = c;
    AluSrc      = src;
    PC_E        = pc;
    signImm_E   = imm;
    readData1_E = a;
    readData2_E = rd2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0;
    set_op(4'b0000, 1'b0, '0, '0, '0, '0);
    valid_in = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({busy, valid_out, zero_M} !== 3'b000 || aluResult_M !== '0 ||
        PCBranch_M !== '0 || writeData_M !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b zero=%b alu=%h pcb=%h wd=%h required all 0",
               busy, valid_out, zero_M, aluResult_M, PCBranch_M, writeData_M);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    @(negedge clk);
    set_op(4'b0010, 1'b0, 64'h40, 64'h3, 64'd5, 64'd7);
    step();
    valid_in = 1'b0;
    n_checks++;
    if (aluResult_M !== 64'd12 || zero_M !== 1'b0 || valid_out !== 1'b1 ||
        writeData_M !== 64'd7 || PCBranch_M !== 64'h4C) begin
      n_fail++;
      $display("FAIL add: alu=%0d zero=%b valid=%b wd=%0d pcb=%h required 12 0 1 7 4c",
               aluResult_M, zero_M, valid_out, writeData_M, PCBranch_M);
    end
    step();
    n_checks++;
    if (valid_out !== 1'b0 || aluResult_M !== 64'd12) begin
      n_fail++;
      $display("FAIL add_idle_hold: valid=%b alu=%0d required 0 12", valid_out, aluResult_M);
    end
  endtask

  task automatic test_sub_branch();
    @(negedge clk);
    set_op(4'b0110, 1'b1, 64'h100, 64'd9, 64'd9, 64'hDEAD);
    step();
    valid_in = 1'b0;
    n_checks++;
    if (aluResult_M !== '0 || zero_M !== 1'b1 || PCBranch_M !== 64'h124 ||
        valid_out !== 1'b1 || writeData_M !== 64'hDEAD) begin
      n_fail++;
      $display("FAIL sub_branch: alu=%h zero=%b pcb=%h valid=%b wd=%h required 0 1 124 1 dead",
               aluResult_M, zero_M, PCBranch_M, valid_out, writeData_M);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    set_op(4'b0010, 1'b0, '0, '0, {N{1'b1}}, 64'd1);
    step();
    valid_in = 1'b0;
    n_checks++;
    if (aluResult_M !== '0 || zero_M !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_add: alu=%h zero=%b required 0 1", aluResult_M, zero_M);
    end
  endtask

  task automatic test_flush_single();
    logic [N-1:0] held;
    held = aluResult_M;
    @(negedge clk);
    set_op(4'b0001, 1'b0, '0, '0, 64'h1234, 64'h8000);
    flush = 1'b1;
    step();
    valid_in = 1'b0; flush = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0 || aluResult_M !== held || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_single: valid=%b alu=%h busy=%b required 0 %h 0",
               valid_out, aluResult_M, busy, held);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   codes [10];
    logic [3:0]   c;
    logic         src;
    logic [N-1:0] pc, imm, a, rd2, b, exp_r, last_r;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
              4'b0011, 4'b0100, 4'b1111, 4'b1010};
    last_r = '0;
    for (int i = 0; i < 40; i++) begin
      c   = codes[$urandom_range(0, 9)];
      src = 1'($urandom_range(0, 1));
      pc  = rand64(); imm = rand64(); a = rand64(); rd2 = rand64();
      if (i % 7 == 3) begin
        c = 4'b0110; rd2 = a; src = 1'b0;
      end
      b     = src ? imm : rd2;
      exp_r = model_alu(c, a, b);
      @(negedge clk);
      set_op(c, src, pc, imm, a, rd2);
      step();
      n_checks++;
      if (valid_out !== 1'b1 || aluResult_M !== exp_r || zero_M !== (exp_r == 0) ||
          PCBranch_M !== pc + imm * 4 || writeData_M !== rd2 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%b: valid=%b alu=%h zero=%b pcb=%h wd=%h required 1 %h %b %h %h",
                 i, c, valid_out, aluResult_M, zero_M, PCBranch_M, writeData_M,
                 exp_r, (exp_r == 0), pc + imm * 4, rd2);
      end
      last_r = exp_r;
    end
    valid_in = 1'b0;
    step();
    n_checks++;
    if (valid_out !== 1'b0 || aluResult_M !== last_r) begin
      n_fail++;
      $display("FAIL b2b_drop: valid=%b alu=%h required 0 %h", valid_out, aluResult_M, last_r);
    end
  endtask

  task automatic test_mul(input logic [N-1:0] a, input logic [N-1:0] b, input logic src);
    logic [N-1:0] pc, imm, rd2, exp_p;
    int got, busy_cnt;
    pc  = rand64();
    imm = src ? b : rand64();
    rd2 = src ? rand64() : b;
    exp_p = model_alu(4'b1000, a, b);
    @(negedge clk);
    set_op(4'b1000, src, pc, imm, a, rd2);
    step();
    n_checks++;
    if (busy !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_start: busy=%b valid=%b required 1 0", busy, valid_out);
    end
    busy_cnt = 1;
    got = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (valid_out === 1'b1) begin
        got = k;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    valid_in = 1'b0;
    n_checks++;
    if (got != N + 1 || busy_cnt != N + 1) begin
      n_fail++;
      $display("FAIL mul_latency: valid_edge=%0d busy_cycles=%0d required %0d %0d",
               got, busy_cnt, N + 1, N + 1);
    end
    n_checks++;
    if (aluResult_M !== exp_p || zero_M !== (exp_p == 0) || busy !== 1'b0 ||
        PCBranch_M !== pc + imm * 4 || writeData_M !== rd2) begin
      n_fail++;
      $display("FAIL mul_result: alu=%h zero=%b busy=%b pcb=%h wd=%h required %h %b 0 %h %h",
               aluResult_M, zero_M, busy, PCBranch_M, writeData_M,
               exp_p, (exp_p == 0), pc + imm * 4, rd2);
    end
    step();
    n_checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_single_valid: valid=%b busy=%b required 0 0", valid_out, busy);
    end
  endtask

  task automatic test_flush_mul();
    int spurious;
    logic [N-1:0] a, b;
    @(negedge clk);
    set_op(4'b1000, 1'b0, '0, '0, rand64(), rand64());
    step();
    valid_in = 1'b0;
    repeat (10) step();
    @(negedge clk);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mul: busy=%b valid=%b required 0 0", busy, valid_out);
    end
    spurious = 0;
    repeat (80) begin
      step();
      if (valid_out !== 1'b0 || busy !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL flush_mul_quiet: spurious=%0d required 0", spurious);
    end
    a = rand64(); b = rand64();
    @(negedge clk);
    set_op(4'b0010, 1'b0, '0, '0, a, b);
    step();
    valid_in = 1'b0;
    n_checks++;
    if (valid_out !== 1'b1 || aluResult_M !== a + b) begin
      n_fail++;
      $display("FAIL flush_then_add: valid=%b alu=%h required 1 %h", valid_out, aluResult_M, a + b);
    end
  endtask

  task automatic test_reset_mid_mul();
    int spurious;
    @(negedge clk);
    set_op(4'b1000, 1'b0, rand64(), rand64(), rand64(), rand64());
    step();
    valid_in = 1'b0;
    repeat (20) step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, valid_out, zero_M} !== 3'b000 || aluResult_M !== '0 ||
        PCBranch_M !== '0 || writeData_M !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: busy=%b valid=%b zero=%b alu=%h pcb=%h wd=%h required all 0",
               busy, valid_out, zero_M, aluResult_M, PCBranch_M, writeData_M);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    repeat (80) begin
      step();
      if (valid_out !== 1'b0 || busy !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0 || aluResult_M !== '0) begin
      n_fail++;
      $display("FAIL reset_mul_quiet: spurious=%0d alu=%h required 0 0", spurious, aluResult_M);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_branch();
    test_wrap();
    test_flush_single();
    test_back_to_back();
    test_mul(64'hFFFF_FFFF, 64'd3, 1'b0);
    test_mul(rand64(), rand64(), 1'b0);
    test_mul(rand64(), {32'd0, $urandom()}, 1'b1);
    test_mul(rand64(), 64'd0, 1'b0);
    test_flush_mul();
    test_reset_mid_mul();
    test_add();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 SHALL have parameter N, default 64, datapath width in bits (N >= 8, power of two).
REQ-002 SHALL have parameter MUL_EN, default 1, enables the iterative multiply op; 0 maps MUL to result 0.
REQ-003 SHALL have clk  input  1  single clock, all state updated on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have valid_in  input  1  operands/controls present this cycle.
REQ-006 SHALL have flush  input  1  discard in-flight and registered op.
REQ-007 SHALL have AluSrc  input  1  0: operand b = readData2_E, 1: b = signImm_E.
REQ-008 SHALL have AluControl  input  4  operation select, encodings in REQ-015.
REQ-009 SHALL have PC_E, signImm_E, readData1_E, readData2_E  input  N each  stage operands.
REQ-010 SHALL have busy  output  1  stall request to upstream; combinational from state.
REQ-011 SHALL have valid_out  output  1  registered results valid.
REQ-012 SHALL have zero_M  output  1  registered (aluResult == 0).
REQ-013 SHALL have PCBranch_M, aluResult_M, writeData_M  output  N each  registered results.

Function
REQ-014 Single-cycle ops: accepted when valid_in & !busy & !flush; results registered on that edge; latency 1; valid_out high exactly 1 cycle per accepted op.
REQ-015 Ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 pass b, 1100 NOR, 1000 MUL (low N bits, unsigned); other codes give result 0.
REQ-016 PCBranch_M = PC_E + (signImm_E << 2), modulo 2^N; writeData_M = readData2_E; both captured at accept, held during MUL.
REQ-017 Arithmetic wraps modulo 2^N; no carry/overflow output.
REQ-018 FSM states IDLE, MUL, DONE; IDLE->MUL on accepted MUL (MUL_EN=1); MUL->DONE after N iterations; DONE->IDLE next cycle; any state ->IDLE on flush.
REQ-019 MUL: shift-add, one multiplier bit per cycle, iteration counter $clog2(N)+1 bits; valid_out asserted the cycle after DONE entry, i.e. N+1 edges after accept.
REQ-020 busy SHALL be high in MUL and DONE, low in IDLE; upstream holds inputs while busy; valid_in ignored while busy.
REQ-021 flush SHALL take priority over valid_in and completion: no accept that cycle, valid_out deasserted next edge, state -> IDLE, partial product discarded.
REQ-022 Back-to-back single-cycle ops SHALL produce valid_out every cycle; op accepted the cycle DONE->IDLE is not possible (busy high in DONE).
REQ-023 When no op is accepted, valid_out SHALL drop to 0; result registers hold last values.

Reset
REQ-024 reset SHALL asynchronously force state IDLE, counter 0, valid_out 0, zero_M 0, all N-bit outputs 0, busy 0.
REQ-025 reset during MUL SHALL abort without producing valid_out after release.

Structure
REQ-026 Package exe_pkg SHALL hold AluControl encodings as localparams and the state enum (IDLE, MUL, DONE).
REQ-027 Sub-module mul_iter (parameter N) SHALL implement the shift-add multiplier with start, done, product ports; execute_mc owns FSM and output registers.

Verification
REQ-028 ADD: a=5, readData2=7, AluSrc=0, AluControl=0010 -> next edge aluResult_M=12, zero_M=0, valid_out=1 one cycle.
REQ-029 SUB/zero + branch: a=9, signImm=9, AluSrc=1, 0110, PC_E=0x100 -> aluResult_M=0, zero_M=1, PCBranch_M=0x124.
REQ-030 MUL: a=0xFFFF_FFFF, b=3 (N=64) -> busy high 65 cycles, valid_out on edge 65 after accept, aluResult_M=0x2_FFFF_FFFD.
REQ-031 flush at iteration 10 of MUL -> busy low next cycle, no valid_out, next ADD completes with latency 1.
REQ-032 reset asserted mid-MUL, released 3 cycles later -> all outputs 0, busy 0, no spurious valid_out.
REQ-033 Wrap: a=0xFFFF_FFFF_FFFF_FFFF + 1 (ADD) -> aluResult_M=0, zero_M=1.
